// File: rtl/scc_mem_pkg.sv
// scc_mem_pkg: shared types and constants for the SCC unified memory arbiter.
//   state_t    : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   req_id_t   : requester identity (instruction fetch or data port)
//   MEM_LAT_*  : legal memory latency range and the wait-counter width
package scc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W   = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/scc_mem_arbiter_if.sv
// scc_mem_arbiter_if: request/response/memory bus of the SCC memory arbiter.
//   slave  modport : the arbiter side (takes requests, drives grants/responses
//                    and the memory strobe)
//   master modport : the core + memory side (drives requests and mem_rdata)
interface scc_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              core_stall;
  logic              starve_force;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, core_stall, starve_force
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, core_stall, starve_force
  );

endinterface

// File: rtl/scc_mem_prio.sv
// scc_mem_prio: winner select between fetch and data plus the fetch
// starvation counter.
//   clk, rst         : clock, synchronous active-high reset
//   i_if_req/i_dm_req: pending requests
//   i_arb_en         : an arbitration is taken this cycle (arbiter idle)
//   o_winner         : requester that wins if an arbitration happens now
//   o_starve_force   : fetch priority currently forced
module scc_mem_prio
  import scc_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_if_req,
  input  logic    i_dm_req,
  input  logic    i_arb_en,
  output req_id_t o_winner,
  output logic    o_starve_force
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force;

  assign w_force        = (r_starve_cnt >= CNT_W'(STARVE_MAX));
  assign o_starve_force = w_force;

  // Data wins by default; fetch wins when alone or when starvation forces it.
  always_comb begin
    o_winner = REQ_DM;
    if (i_if_req && (!i_dm_req || w_force)) begin
      o_winner = REQ_IF;
    end
  end

  // A data win against a pending fetch only happens while w_force is low,
  // so the increment saturates at STARVE_MAX by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_arb_en && (i_if_req || i_dm_req)) begin
      if (o_winner == REQ_IF) begin
        r_starve_cnt <= '0;
      end else if (i_if_req) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scc_mem_arbiter.sv
// scc_mem_arbiter: single-outstanding arbiter for the unified instruction/data
// memory port of the SCC core. Data has priority; a starvation counter forces
// a fetch after STARVE_MAX consecutive data wins against a pending fetch.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch (if_*), data (dm_*), memory (mem_*) channels plus
//              core_stall and starve_force
module scc_mem_arbiter
  import scc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  scc_mem_arbiter_if.slave  bus
);

  if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_lat
    $error("scc_mem_arbiter: MEM_LAT out of range");
  end

  state_t              r_state;
  req_id_t             r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic                r_if_gnt, r_dm_gnt;
  logic                r_if_rvalid, r_dm_rvalid;
  logic                r_mem_en, r_mem_we;
  logic [DATA_W-1:0]   r_if_rdata, r_dm_rdata;

  req_id_t             w_winner;
  logic                w_arb_en;
  logic                w_any_req;

  assign w_arb_en  = (r_state == ST_IDLE);
  assign w_any_req = bus.if_req || bus.dm_req;

  scc_mem_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk           (clk),
    .rst           (rst),
    .i_if_req      (bus.if_req),
    .i_dm_req      (bus.dm_req),
    .i_arb_en      (w_arb_en),
    .o_winner      (w_winner),
    .o_starve_force(bus.starve_force)
  );

  // Registered strobes are loaded on the transition into the state they
  // belong to, so gnt/mem_en are high during ISSUE and rvalid during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_id        <= REQ_IF;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lat_cnt   <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_id     <= w_winner;
            r_mem_en <= 1'b1;
            r_state  <= ST_ISSUE;
            if (w_winner == REQ_DM) begin
              r_we     <= bus.dm_we;
              r_addr   <= bus.dm_addr;
              r_wdata  <= bus.dm_wdata;
              r_mem_we <= bus.dm_we;
              r_dm_gnt <= 1'b1;
            end else begin
              r_we     <= 1'b0;
              r_addr   <= bus.if_addr;
              r_wdata  <= '0;
              r_if_gnt <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            if (r_id == REQ_IF) begin
              r_if_rdata  <= bus.mem_rdata;
              r_if_rvalid <= 1'b1;
            end else begin
              if (!r_we) begin
                r_dm_rdata <= bus.mem_rdata;
              end
              r_dm_rvalid <= 1'b1;
            end
            r_state <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt    = r_if_gnt;
  assign bus.dm_gnt    = r_dm_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  // Low in RESP so the core consumes rdata on the rvalid edge.
  assign bus.core_stall = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                          ((r_state == ST_IDLE) && w_any_req);

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// tb_scc_mem_arbiter: three arbiter instances (MEM_LAT = 1, 2, 4) with a
// behavioural memory each; a scoreboard queue per instance holds expected
// accesses in grant order.
module tb_scc_mem_arbiter;
  import scc_mem_pkg::*;

  localparam int NI = 3;

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req [NI], dm_req [NI], dm_we [NI];
  logic [31:0] if_addr [NI], dm_addr [NI], dm_wdata [NI], mem_rdata [NI];
  logic        if_gnt [NI], if_rvalid [NI], dm_gnt [NI], dm_rvalid [NI];
  logic        mem_en [NI], mem_we [NI], core_stall [NI], starve_force [NI];
  logic [31:0] if_rdata [NI], dm_rdata [NI], mem_addr [NI], mem_wdata [NI];

  for (genvar g = 0; g < NI; g++) begin : G
    scc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr[g];
    assign bus.dm_req    = dm_req[g];
    assign bus.dm_we     = dm_we[g];
    assign bus.dm_addr   = dm_addr[g];
    assign bus.dm_wdata  = dm_wdata[g];
    assign bus.mem_rdata = mem_rdata[g];
    assign if_gnt[g]       = bus.if_gnt;
    assign if_rvalid[g]    = bus.if_rvalid;
    assign if_rdata[g]     = bus.if_rdata;
    assign dm_gnt[g]       = bus.dm_gnt;
    assign dm_rvalid[g]    = bus.dm_rvalid;
    assign dm_rdata[g]     = bus.dm_rdata;
    assign mem_en[g]       = bus.mem_en;
    assign mem_we[g]       = bus.mem_we;
    assign mem_addr[g]     = bus.mem_addr;
    assign mem_wdata[g]    = bus.mem_wdata;
    assign core_stall[g]   = bus.core_stall;
    assign starve_force[g] = bus.starve_force;

    scc_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(g)), .STARVE_MAX(4)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          req_cyc;
    bit          chk_lat;
  } sb_t;

  typedef struct {
    int          k;
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  sb_t         sbq [NI][$];
  int          gnt_cyc [NI];
  int          last_en [NI];
  logic [31:0] last_if [NI], last_dm [NI];
  logic [31:0] memm   [logic [33:0]];
  logic [31:0] shadow [logic [33:0]];
  logic [31:0] pipe [NI][4];

  function automatic void chk(input string name, input int k,
                              input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", name, k, got, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] deflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] sh_rd(input int k, input logic [31:0] a);
    logic [33:0] key;
    key = {2'(k), a};
    if (shadow.exists(key)) return shadow[key];
    return deflt(a);
  endfunction

  task automatic mon_one(input int k);
    int  L;
    bit  any_g;
    sb_t e;
    L     = int'(lat_of(k));
    any_g = if_gnt[k] || dm_gnt[k];
    if (if_gnt[k] && dm_gnt[k]) chk("dual_gnt", k, 32'd1, 32'd0);
    if (any_g || mem_en[k]) chk("mem_en_eq_gnt", k, 32'(mem_en[k]), 32'(any_g));
    if (any_g) begin
      if (sbq[k].size() == 0) chk("unexp_gnt", k, 32'd1, 32'd0);
      else begin
        e = sbq[k][0];
        chk("gnt_id", k, 32'(dm_gnt[k]), 32'(e.dm));
        if (e.chk_lat) chk("gnt_lat", k, 32'(cyc - e.req_cyc), 32'd1);
        gnt_cyc[k] = cyc;
      end
    end
    if (mem_en[k]) begin
      chk("issue_spacing", k, 32'(cyc - last_en[k] >= L + 3), 32'd1);
      last_en[k] = cyc;
      if (sbq[k].size() != 0) begin
        e = sbq[k][0];
        chk("mem_addr", k, mem_addr[k], e.addr);
        chk("mem_we", k, 32'(mem_we[k]), 32'(e.we));
        if (e.we) chk("mem_wdata", k, mem_wdata[k], e.wdata);
      end
    end
    if (if_rvalid[k] || dm_rvalid[k]) begin
      if (sbq[k].size() == 0) chk("unexp_rvalid", k, 32'd1, 32'd0);
      else begin
        e = sbq[k].pop_front();
        chk("rvalid_id", k, 32'(dm_rvalid[k]), 32'(e.dm));
        chk("rvalid_lat", k, 32'(cyc - gnt_cyc[k]), 32'(L + 1));
        chk("stall_resp", k, 32'(core_stall[k]), 32'd0);
        if (e.dm) begin
          chk("if_rdata_hold", k, if_rdata[k], last_if[k]);
          if (e.we) chk("dm_rdata_hold", k, dm_rdata[k], last_dm[k]);
          else begin
            chk("dm_rdata", k, dm_rdata[k], e.exp);
            last_dm[k] = e.exp;
          end
        end else begin
          chk("dm_rdata_hold", k, dm_rdata[k], last_dm[k]);
          chk("if_rdata", k, if_rdata[k], e.exp);
          last_if[k] = e.exp;
        end
      end
    end
  endtask

  // Memory model: data read in cycle A is presented for the whole of cycle
  // A+MEM_LAT; every other cycle carries junk so a mistimed capture shows.
  task automatic mem_step(input int k);
    logic [33:0] key;
    key = {2'(k), mem_addr[k]};
    if (mem_en[k] && mem_we[k]) memm[key] = mem_wdata[k];
    for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
    if (mem_en[k] && !mem_we[k])
      pipe[k][0] = memm.exists(key) ? memm[key] : deflt(mem_addr[k]);
    else
      pipe[k][0] = 32'h0BAD0BAD ^ 32'(cyc);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        mon_one(k);
        mem_step(k);
      end
    end
  endtask

  task automatic clocker();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < NI; k++) mem_rdata[k] = pipe[k][lat_of(k) - 1];
    end
  endtask

  task automatic watchdog();
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  task automatic access(input int k, input bit dm, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp);
    bit got;
    sb_t e;
    @(posedge clk); #1;
    chk("stall_idle", k, 32'(core_stall[k]), 32'd0);
    if (dm) begin
      dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
      if (we) shadow[{2'(k), addr}] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    e = '{dm: dm, we: we, addr: addr, wdata: wdata, exp: exp, req_cyc: cyc, chk_lat: 1'b1};
    sbq[k].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("stall_req", k, 32'(core_stall[k]), 32'd1);
      got = dm ? dm_gnt[k] : if_gnt[k];
    end
    if (!got) begin
      chk("gnt_timeout", k, 32'd0, 32'd1);
      sbq[k].delete();
      if_req[k] = 1'b0; dm_req[k] = 1'b0;
      return;
    end
    chk("stall_gnt", k, 32'(core_stall[k]), 32'd1);
    @(posedge clk); #1;
    if_req[k] = 1'b0; dm_req[k] = 1'b0;
    @(negedge clk);
    chk("stall_wait", k, 32'(core_stall[k]), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i != 0) @(negedge clk);
      got = dm ? dm_rvalid[k] : if_rvalid[k];
    end
    if (!got) begin
      chk("rvalid_timeout", k, 32'd0, 32'd1);
      sbq[k].delete();
    end
  endtask

  initial begin
    vec_t vecs [$];
    bit   sf_exp [6];
    int   ng, ndm;
    bit   drop_if, drop_dm, got;
    bit   dm, we;
    logic [31:0] addr, wdata;
    sb_t  e;

    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
      if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0; mem_rdata[k] = '0;
      gnt_cyc[k] = 0; last_en[k] = -100; last_if[k] = '0; last_dm[k] = '0;
      for (int i = 0; i < 4; i++) pipe[k][i] = 32'h0BAD0BAD;
    end
    memm[{2'd0, 32'h10}]   = 32'hE1234567;
    shadow[{2'd0, 32'h10}] = 32'hE1234567;

    fork
      monitor();
      clocker();
      watchdog();
    join_none

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_if_gnt", k, 32'(if_gnt[k]), 32'd0);
      chk("rst_dm_gnt", k, 32'(dm_gnt[k]), 32'd0);
      chk("rst_if_rvalid", k, 32'(if_rvalid[k]), 32'd0);
      chk("rst_dm_rvalid", k, 32'(dm_rvalid[k]), 32'd0);
      chk("rst_mem_en", k, 32'(mem_en[k]), 32'd0);
      chk("rst_mem_we", k, 32'(mem_we[k]), 32'd0);
      chk("rst_mem_addr", k, mem_addr[k], 32'd0);
      chk("rst_if_rdata", k, if_rdata[k], 32'd0);
      chk("rst_dm_rdata", k, dm_rdata[k], 32'd0);
      chk("rst_stall", k, 32'(core_stall[k]), 32'd0);
      chk("rst_starve_force", k, 32'(starve_force[k]), 32'd0);
    end
    rst = 1'b0;

    // Directed vectors: {instance, dm, we, addr, wdata, expected rdata}
    vecs.push_back('{0, 1'b0, 1'b0, 32'h00000010, 32'h0,        32'hE1234567});
    vecs.push_back('{1, 1'b1, 1'b1, 32'h00000200, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h00000200, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1, 1'b0, 1'b0, 32'h00000010, 32'h0,        deflt(32'h10)});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h00000103, 32'h0,        deflt(32'h103)});
    vecs.push_back('{0, 1'b1, 1'b1, 32'h00000102, 32'h12345678, 32'h0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h00000102, 32'h0,        32'h12345678});
    vecs.push_back('{2, 1'b0, 1'b0, 32'h00000020, 32'h0,        deflt(32'h20)});
    vecs.push_back('{2, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{2, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF});
    vecs.push_back('{2, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFF});
    vecs.push_back('{1, 1'b1, 1'b0, 32'h00000000, 32'h0,        deflt(32'h0)});
    foreach (vecs[i])
      access(vecs[i].k, vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Starvation: both requests held on instance 0, grant order DM x4, IF, DM
    sf_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(posedge clk); #1;
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h300;
    for (int j = 0; j < 6; j++) begin
      e.dm = (j != 4); e.we = 1'b0; e.wdata = '0;
      e.addr = (j == 4) ? 32'h40 : 32'h300;
      e.exp = sh_rd(0, e.addr); e.req_cyc = cyc; e.chk_lat = (j == 0);
      sbq[0].push_back(e);
    end
    ng = 0; ndm = 0;
    for (int i = 0; i < 200 && sbq[0].size() != 0; i++) begin
      @(negedge clk);
      if (if_gnt[0] || dm_gnt[0]) begin
        if (ng < 6) chk("starve_force_at_gnt", 0, 32'(starve_force[0]), 32'(sf_exp[ng]));
        ng++;
        if (dm_gnt[0]) ndm++;
        drop_if = if_gnt[0];
        drop_dm = dm_gnt[0] && (ndm == 5);
        @(posedge clk); #1;
        if (drop_if) if_req[0] = 1'b0;
        if (drop_dm) dm_req[0] = 1'b0;
      end
    end
    chk("starve_gnt_count", 0, 32'(ng), 32'd6);
    chk("starve_pending", 0, 32'(sbq[0].size()), 32'd0);
    sbq[0].delete();
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT on instance 1: the access is abandoned
    @(posedge clk); #1;
    dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h500;
    e = '{dm: 1'b1, we: 1'b0, addr: 32'h500, wdata: 32'h0, exp: 32'h0, req_cyc: cyc, chk_lat: 1'b1};
    sbq[1].push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = dm_gnt[1];
    end
    chk("rstwait_gnt", 1, 32'(got), 32'd1);
    @(posedge clk); #1;
    dm_req[1] = 1'b0;
    rst = 1'b1;
    sbq[1].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      last_if[k] = '0; last_dm[k] = '0; last_en[k] = -100;
      chk("rstwait_mem_en", k, 32'(mem_en[k]), 32'd0);
      chk("rstwait_mem_we", k, 32'(mem_we[k]), 32'd0);
      chk("rstwait_stall", k, 32'(core_stall[k]), 32'd0);
      chk("rstwait_force", k, 32'(starve_force[k]), 32'd0);
      chk("rstwait_dm_rdata", k, dm_rdata[k], 32'd0);
    end
    repeat (8) @(negedge clk);
    access(1, 1'b1, 1'b0, 32'h500, 32'h0, deflt(32'h500));

    // Back-to-back random accesses at MEM_LAT = 4
    for (int n = 0; n < 20; n++) begin
      dm    = ($urandom_range(0, 1) == 1);
      we    = dm && ($urandom_range(0, 1) == 1);
      addr  = 32'($urandom_range(0, 7)) << 2;
      wdata = $urandom;
      access(2, dm, we, addr, wdata, we ? 32'h0 : sh_rd(2, addr));
    end

    repeat (6) @(negedge clk);
    for (int k = 0; k < NI; k++) chk("sb_empty", k, 32'(sbq[k].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scc_mem_arbiter.md
Name: scc_mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory port between instruction fetch and data load/store in the SCC core.
- One access outstanding at a time.
- Data requests have priority over fetch; a starvation counter guarantees fetch forward progress.
- Drives `core_stall` so the fetch/decode/execute path freezes while an access is in flight.
- Sits between the IF/MEM stages and the instruction_and_data memory.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MEM_LAT, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..4
- STARVE_MAX, 4, consecutive data wins allowed against a pending fetch before fetch is forced

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address (the PC)
- if_gnt  out  1  one-cycle pulse; fetch issued to memory
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction; held until the next fetch response
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse; data access issued
- dm_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledged
- dm_rdata  out  DATA_W  load data; held until the next data load response
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- core_stall  out  1  freeze core pipeline
- starve_force  out  1  level; fetch priority currently forced

Behaviour:
- Clocking and reset: one clock domain, `clk`. Synchronous active-high `rst`. The following reset to 0:
  - all outputs
  - `rdata` registers
  - latched request
  - starve counter
  - state (reset to IDLE)
- Reset mid-access: abandons the access. No rvalid or gnt is produced for it. `mem_en`/`mem_we` are 0 in the cycle after `rst` is sampled.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - If any request is pending, arbitrate, latch the winner's addr/we/wdata/id, and go to ISSUE.
    - Else stay in IDLE.
  - ISSUE (cycle A):
    - `mem_en=1`; `mem_we` = latched we (0 for fetch); `mem_addr`/`mem_wdata` from the latch.
    - Winner's gnt = 1.
    - Load wait counter with MEM_LAT-1; go to WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - At count 0 (cycle A+MEM_LAT), capture `mem_rdata` into the winner's rdata register (loads and fetches only; stores leave `dm_rdata` unchanged). Go to RESP.
  - RESP (cycle A+MEM_LAT+1): winner's rvalid = 1; go to IDLE.
- Latency: request seen in IDLE at cycle N gives:
  - gnt at N+1
  - rvalid at N+2+MEM_LAT
  - minimum spacing between issues of MEM_LAT+3 cycles
- Arbitration, when both requests are pending in IDLE:
  - `starve_cnt >= STARVE_MAX`: fetch wins.
  - Otherwise: data wins.
- Arbitration, when a single request is pending: it wins.
- `starve_cnt`:
  - Increments (saturating at STARVE_MAX) when data wins while `if_req=1`.
  - Clears on a fetch win.
  - Width is clog2(STARVE_MAX+1).
- `starve_force` = (`starve_cnt >= STARVE_MAX`).
- `core_stall` = (state ∈ {ISSUE, WAIT}) | (state == IDLE & (`if_req` | `dm_req`)).
  - Low in RESP, so the core consumes rdata on the rvalid edge.
- Requester rules:
  - addr/we/wdata stable from req rise until gnt.
  - req must be low in the cycle after its rvalid unless a new access is intended.
  - req may drop only after gnt.
- Misaligned addresses (`addr[1:0]!=0`) are passed through unmodified; alignment checking is not this block's job.
- Registered rvalid/gnt/mem_* outputs; `core_stall` and `starve_force` are combinational from state and inputs.

Decomposition:
- Shared package `scc_mem_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT/RESP)
  - requester id enum (REQ_IF, REQ_DM)
  - MEM_LAT legal-range constants
- Natural sub-module `scc_mem_prio`: combinational winner select plus the starve counter register.
- The FSM and datapath latches stay in the top module.

Test Plan:
- Fetch only, MEM_LAT=1, if_addr=0x10, mem_rdata=0xE1234567 → if_gnt at N+1; mem_en one cycle with mem_addr=0x10; if_rvalid at N+3 with if_rdata=0xE1234567; core_stall low at N+3.
- Store then load, MEM_LAT=2: dm_we=1, addr 0x200, wdata 0xDEADBEEF; then load 0x200 returning 0xDEADBEEF → mem_we=1 on the first issue only; dm_rvalid for the store at N+4; dm_rdata=0xDEADBEEF after the load.
- Simultaneous if_req and dm_req held continuously, STARVE_MAX=4 → grant order DM,DM,DM,DM,IF,DM…; starve_force high before the 5th arbitration and low after the fetch grant.
- rst asserted during WAIT → no rvalid ever for that access; mem_en=0; state IDLE; starve_cnt=0; the next request is served with normal latency.
- MEM_LAT=4 sweep, 20 random back-to-back requests → every access has rvalid exactly MEM_LAT+1 cycles after its gnt; never two mem_en within MEM_LAT+3 cycles.
